// File: rtl/bus_pkg.sv
// bus_pkg: shared encodings and default widths for the bus arbiter slice.
package bus_pkg;

  localparam int unsigned DEF_ADDR_W = 64;
  localparam int unsigned DEF_DATA_W = 64;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Completion response codes driven on HRESP
  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } hresp_t;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector; the search starts one past 'last' and wraps.
module rr_picker #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  // Walk the N candidates in priority order; the first requester found wins
  always_comb begin
    int unsigned cand;
    cand    = 0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (32'(last) + off) % N;
      if (!any && req[IDX_W'(cand)]) begin
        any     = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master round-robin arbiter sequencing one transfer at a time onto a
// multi-cycle peripheral port (IDLE -> XFER -> DONE).
// Build option ARB_TIMEOUT_EN: an XFER lacking PREADY for TIMEOUT cycles completes with
// HRESP=ERROR and HRDATA=0; without it XFER waits indefinitely and HRESP stays OKAY.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          HTRANS,
  input  logic [N_MASTERS*ADDR_W-1:0]   HADDR,
  input  logic [N_MASTERS-1:0]          HWRITE,
  input  logic [N_MASTERS*DATA_W-1:0]   HWDATA,
  output logic [DATA_W-1:0]             HRDATA,
  output logic [N_MASTERS-1:0]          HREADY,
  output logic                          HRESP,
  output logic [N_MASTERS-1:0]          stall,
  output logic                          PSEL,
  output logic [ADDR_W-1:0]             PADDR,
  output logic                          PWRITE,
  output logic [DATA_W-1:0]             PDATA,
  input  logic [DATA_W-1:0]             PRDATA,
  input  logic                          PREADY
);

  localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  state_t               state;
  logic [IDX_W-1:0]     last;
  logic [IDX_W-1:0]     grant;
  logic [IDX_W-1:0]     pick;
  logic                 req_any;
  logic [N_MASTERS-1:0] grant_oh;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tcnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
`endif

  rr_picker #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req     (HTRANS),
    .last    (last),
    .gnt_idx (pick),
    .any     (req_any)
  );

  // Completion pulse target for the master currently holding the grant
  assign grant_oh = {{(N_MASTERS-1){1'b0}}, 1'b1} << grant;

  // A requesting master is stalled every cycle except its own completion cycle
  assign stall = HTRANS & ~HREADY;

  // Sequencer: grant and latch in IDLE, hold the peripheral port in XFER, pulse HREADY in DONE
  always_ff @(posedge CLK) begin
    if (reset) begin
      state  <= IDLE;
      last   <= IDX_W'(N_MASTERS - 1);
      grant  <= '0;
      PSEL   <= 1'b0;
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PDATA  <= '0;
      HRDATA <= '0;
      HREADY <= '0;
      HRESP  <= OKAY;
`ifdef ARB_TIMEOUT_EN
      tcnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            grant  <= pick;
            last   <= pick;
            PADDR  <= HADDR[pick*ADDR_W +: ADDR_W];
            PWRITE <= HWRITE[pick];
            PDATA  <= HWDATA[pick*DATA_W +: DATA_W];
            PSEL   <= 1'b1;
            state  <= XFER;
`ifdef ARB_TIMEOUT_EN
            tcnt   <= '0;
`endif
          end
        end
        XFER: begin
          if (PREADY) begin
            if (!PWRITE) begin
              HRDATA <= PRDATA;
            end
            HRESP  <= OKAY;
            HREADY <= grant_oh;
            PSEL   <= 1'b0;
            state  <= DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tcnt == TO_LAST) begin
            HRDATA <= '0;
            HRESP  <= ERROR;
            HREADY <= grant_oh;
            PSEL   <= 1'b0;
            state  <= DONE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
`endif
        end
        DONE: begin
          HREADY <= '0;
          HRESP  <= OKAY;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
